// File: rtl/cache_flush_controller.sv
// FENCE.I sequencer: clean D-cache, drain write-backs, invalidate I-cache, redirect fetch once.
// Latency D+I+2 cycles to redirect; FLUSH_OVERLAP_EN runs the I-cache sweep alongside the clean.
// Backpressure: ready-low / wb-busy cycles extend the flush; o_stall_out holds MEM throughout.
module cache_flush_controller #(
  parameter int DCACHE_LINES = 64,
  parameter int ICACHE_LINES = 64
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_flush_req,
  input  logic [63:0]                     i_flush_target_pc,
  output logic                            o_stall_out,
  output logic                            o_dclean_valid,
  output logic [$clog2(DCACHE_LINES)-1:0] o_dclean_idx,
  input  logic                            i_dclean_ready,
  input  logic                            i_dcache_wb_idle,
  output logic                            o_iinv_en,
  output logic [$clog2(ICACHE_LINES)-1:0] o_iinv_idx,
  output logic                            o_redirect_valid,
  output logic [63:0]                     o_redirect_pc,
  output logic                            o_busy
);

  localparam int DW = $clog2(DCACHE_LINES);
  localparam int IW = $clog2(ICACHE_LINES);
  localparam logic [DW-1:0] D_LAST = DW'(DCACHE_LINES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(ICACHE_LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DCLEAN,
    S_DRAIN,
    S_IINV,
    S_REDIRECT
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_d_cnt;
  logic [IW-1:0] r_i_cnt;
  logic [63:0]   r_target;
  logic          r_dclean_valid;
  logic          r_iinv_en;
  logic          r_redirect_valid;
  logic [63:0]   r_redirect_pc;
`ifdef FLUSH_OVERLAP_EN
  logic          r_i_done;
`endif

  logic w_d_last;
  logic w_i_last;

  assign w_d_last = (r_d_cnt == D_LAST);
  assign w_i_last = (r_i_cnt == I_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_d_cnt          <= '0;
      r_i_cnt          <= '0;
      r_target         <= '0;
      r_dclean_valid   <= 1'b0;
      r_iinv_en        <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
`ifdef FLUSH_OVERLAP_EN
      r_i_done         <= 1'b0;
`endif
    end else begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      // The I-cache sweep runs off its own strobe so it can overlap DCLEAN when enabled.
      if (r_iinv_en) begin
        r_i_cnt <= r_i_cnt + 1'b1;
        if (w_i_last) begin
          r_iinv_en <= 1'b0;
`ifdef FLUSH_OVERLAP_EN
          r_i_done  <= 1'b1;
`endif
        end
      end
      case (r_state)
        S_IDLE: begin
          r_d_cnt <= '0;
          r_i_cnt <= '0;
`ifdef FLUSH_OVERLAP_EN
          r_i_done <= 1'b0;
`endif
          if (i_flush_req) begin
            r_target       <= i_flush_target_pc;
            r_dclean_valid <= 1'b1;
            r_state        <= S_DCLEAN;
`ifdef FLUSH_OVERLAP_EN
            r_iinv_en      <= 1'b1;
`endif
          end
        end
        S_DCLEAN: begin
          if (i_dclean_ready) begin
            r_d_cnt <= r_d_cnt + 1'b1;
            if (w_d_last) begin
              r_dclean_valid <= 1'b0;
              r_state        <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (i_dcache_wb_idle) begin
`ifdef FLUSH_OVERLAP_EN
            if (r_i_done || (r_iinv_en && w_i_last)) begin
              r_redirect_valid <= 1'b1;
              r_redirect_pc    <= r_target;
              r_state          <= S_REDIRECT;
            end else begin
              r_state <= S_IINV;
            end
`else
            r_iinv_en <= 1'b1;
            r_state   <= S_IINV;
`endif
          end
        end
        S_IINV: begin
          if (r_iinv_en && w_i_last) begin
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= r_target;
            r_state          <= S_REDIRECT;
          end
        end
        S_REDIRECT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy           = (r_state != S_IDLE);
  assign o_stall_out      = i_flush_req || o_busy;
  assign o_dclean_valid   = r_dclean_valid;
  assign o_dclean_idx     = r_d_cnt;
  assign o_iinv_en        = r_iinv_en;
  assign o_iinv_idx       = r_i_cnt;
  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_cache_flush_controller.sv
// Directed bench for cache_flush_controller: table of flush scenarios plus reset and busy-request sequences.
module tb_cache_flush_controller;

  localparam int DL = 64;
  localparam int IL = 64;
  localparam int DW = $clog2(DL);
  localparam int IW = $clog2(IL);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush_req = 1'b0;
  logic [63:0]   flush_target_pc = '0;
  logic          stall_out;
  logic          dclean_valid;
  logic [DW-1:0] dclean_idx;
  logic          dclean_ready = 1'b1;
  logic          dcache_wb_idle = 1'b1;
  logic          iinv_en;
  logic [IW-1:0] iinv_idx;
  logic          redirect_valid;
  logic [63:0]   redirect_pc;
  logic          busy;

  int n_cmp = 0;
  int n_fail = 0;
  int red_total = 0;
  int busy_req_seen = 0;

  cache_flush_controller #(.DCACHE_LINES(DL), .ICACHE_LINES(IL)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush_req(flush_req), .i_flush_target_pc(flush_target_pc),
    .o_stall_out(stall_out), .o_dclean_valid(dclean_valid), .o_dclean_idx(dclean_idx),
    .i_dclean_ready(dclean_ready), .i_dcache_wb_idle(dcache_wb_idle),
    .o_iinv_en(iinv_en), .o_iinv_idx(iinv_idx), .o_redirect_valid(redirect_valid),
    .o_redirect_pc(redirect_pc), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // A request arriving while busy is illegal upstream; record every occurrence.
  always @(negedge clk) begin
    if (!rst && busy && flush_req) begin
      busy_req_seen++;
      $display("note: flush_req seen while busy at %0t", $time);
    end
    if (redirect_valid) red_total++;
  end

  typedef struct {
    logic [63:0] pc;
    int ready_mode;     // 0: always ready, 1: ready low on odd cycles
    int idle_low;       // cycles wb_idle held low after the last clean handshake
    int extra_cycle;    // cycle of a second flush_req pulse, 0 = none
    int exp_redirect;
    int exp_lows;
    int exp_first_iinv;
    int exp_both;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int c, last_hs, hs, inv, lows, both, idx_err, stall_err, red_cnt, red_cyc, first_inv, first_d;
    logic [63:0] red_pc;
    logic [DW-1:0] exp_d;
    logic [IW-1:0] exp_i;
    bit done;
    c = 0; last_hs = -1; hs = 0; inv = 0; lows = 0; both = 0; idx_err = 0; stall_err = 0;
    red_cnt = 0; red_cyc = -1; first_inv = -1; first_d = -1; red_pc = '0;
    exp_d = '0; exp_i = '0; done = 0;
    flush_req = 1'b1;
    flush_target_pc = v.pc;
    dclean_ready = 1'b1;
    dcache_wb_idle = 1'b1;
    #1;
    chk($sformatf("v%0d stall_req_cycle", id), stall_out, 1);
    chk($sformatf("v%0d busy_req_cycle", id), busy, 0);
    while (!done && c < 1000) begin
      @(posedge clk); #1;
      c++;
      flush_req = (c == v.extra_cycle);
      flush_target_pc = 64'hDEAD_BEEF_0BAD_F00D;
      dclean_ready = (v.ready_mode == 0) || (c % 2 == 0);
      dcache_wb_idle = !(last_hs >= 0 && c > last_hs && c <= last_hs + v.idle_low);
      #1;
      if (!stall_out) stall_err++;
      if (dclean_valid) begin
        if (first_d < 0) first_d = int'(dclean_idx);
        if (dclean_idx != exp_d) idx_err++;
        if (dclean_ready) begin
          exp_d++;
          hs++;
          if (hs == DL) last_hs = c;
        end else begin
          lows++;
        end
      end
      if (iinv_en) begin
        if (first_inv < 0) first_inv = c;
        if (iinv_idx != exp_i) idx_err++;
        exp_i++;
        inv++;
      end
      if (dclean_valid && iinv_en) both++;
      if (redirect_valid) begin
        red_cnt++;
        red_cyc = c;
        red_pc = redirect_pc;
        done = 1;
      end
    end
    @(posedge clk); #1;
    flush_req = 1'b0;
    dclean_ready = 1'b1;
    dcache_wb_idle = 1'b1;
    #1;
    chk($sformatf("v%0d redirect_seen", id), red_cnt, 1);
    chk($sformatf("v%0d redirect_cycle", id), red_cyc, v.exp_redirect);
    chk($sformatf("v%0d redirect_pc", id), red_pc, v.pc);
    chk($sformatf("v%0d clean_handshakes", id), hs, DL);
    chk($sformatf("v%0d iinv_strobes", id), inv, IL);
    chk($sformatf("v%0d first_dclean_idx", id), first_d, 0);
    chk($sformatf("v%0d index_errors", id), idx_err, 0);
    chk($sformatf("v%0d ready_low_cycles", id), lows, v.exp_lows);
    chk($sformatf("v%0d first_iinv_cycle", id), first_inv, v.exp_first_iinv);
    chk($sformatf("v%0d clean_iinv_overlap", id), both, v.exp_both);
    chk($sformatf("v%0d stall_during_flush", id), stall_err, 0);
    chk($sformatf("v%0d stall_after", id), stall_out, 0);
    chk($sformatf("v%0d busy_after", id), busy, 0);
    chk($sformatf("v%0d redirect_one_cycle", id), redirect_valid, 0);
    chk($sformatf("v%0d iinv_after", id), iinv_en, 0);
  endtask

  initial begin
`ifdef FLUSH_OVERLAP_EN
    vecs[0] = '{64'h0000_0000_8000_0104, 0, 0,  0,  66,  0, 1, 64};
    vecs[1] = '{64'h0000_0000_4000_0010, 1, 0,  0, 130, 64, 1, 64};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFC, 0, 10, 0,  76,  0, 1, 64};
    vecs[3] = '{64'h1234_5678_9ABC_DEF0, 1, 3,  0, 133, 64, 1, 64};
    vecs[4] = '{64'h0000_0000_0000_2000, 0, 0,  5,  66,  0, 1, 64};
`else
    vecs[0] = '{64'h0000_0000_8000_0104, 0, 0,  0, 130,  0,  66, 0};
    vecs[1] = '{64'h0000_0000_4000_0010, 1, 0,  0, 194, 64, 130, 0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFC, 0, 10, 0, 140,  0,  76, 0};
    vecs[3] = '{64'h1234_5678_9ABC_DEF0, 1, 3,  0, 197, 64, 133, 0};
    vecs[4] = '{64'h0000_0000_0000_2000, 0, 0,  5, 130,  0,  66, 0};
`endif

    // Reset state: outputs idle, stall follows flush_req combinationally.
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_dclean_valid", dclean_valid, 0);
    chk("rst_iinv_en", iinv_en, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_stall_low", stall_out, 0);
    flush_req = 1'b1;
    #1;
    chk("rst_stall_follows_req", stall_out, 1);
    flush_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_held_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 4; k++) run_vec(k, vecs[k]);

    // Second request while busy must be ignored (target and timing unchanged).
    busy_req_seen = 0;
    run_vec(4, vecs[4]);
    chk("busy_req_flagged", busy_req_seen, 1);

    // Asynchronous reset in the middle of the I-cache sweep.
    flush_req = 1'b1;
    flush_target_pc = 64'h0000_0000_8000_0104;
    @(posedge clk); #1;
    flush_req = 1'b0;
    begin
      int guard;
      guard = 0;
      while (!(iinv_en && iinv_idx == IW'(20)) && guard < 500) begin
        @(posedge clk); #1;
        guard++;
      end
      chk("rst_mid_reached_idx20", guard < 500, 1);
    end
    #2;
    begin
      int red_before;
      red_before = red_total;
      rst = 1'b1;
      #1;
      chk("rst_mid_stall", stall_out, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_dclean_valid", dclean_valid, 0);
      chk("rst_mid_iinv_en", iinv_en, 0);
      chk("rst_mid_iinv_idx", iinv_idx, 0);
      chk("rst_mid_dclean_idx", dclean_idx, 0);
      chk("rst_mid_redirect_valid", redirect_valid, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (150) @(posedge clk);
      #1;
      chk("rst_mid_no_redirect", red_total, red_before);
    end
    run_vec(5, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
